axis_tiny_packet_fifo: RTL and testbench
========================================

Name: axis_tiny_packet_fifo

Overview:
- Next-generation tiny AXI-Stream FIFO: register-based, parametrised depth and byte width, carries tkeep/tuser sidebands, and exposes occupancy and packet counters.
- Adds an optional store-and-forward packet mode. In that mode the output presents data only once a complete packet (tlast) is buffered, with a cut-through escape when the FIFO fills.
- Sits between AXIS producers and consumers as a skid buffer or packet gate.

Parameters:
- FIFO_DEPTH, 4, number of entries; power of two, >= 2.
- BUS_WIDTH, 8, data width in bytes; tdata is BUS_WIDTH*8 bits and tkeep is BUS_WIDTH bits.
- USER_WIDTH, 1, tuser width in bits, >= 1.
- PACKET_MODE, 0, 0 = plain FIFO (first-word fall-through); 1 = store-and-forward with cut-through escape.

Ports:
- aclk  in  1  clock; all logic on rising edge.
- arst  in  1  asynchronous, active-high reset.
- s_axis_tdata  in  BUS_WIDTH*8  input data.
- s_axis_tkeep  in  BUS_WIDTH  input byte enables; stored verbatim.
- s_axis_tuser  in  USER_WIDTH  input user sideband; stored verbatim.
- s_axis_tlast  in  1  end of packet.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  FIFO can accept a word.
- m_axis_tdata  out  BUS_WIDTH*8  output data.
- m_axis_tkeep  out  BUS_WIDTH  output byte enables.
- m_axis_tuser  out  USER_WIDTH  output user sideband.
- m_axis_tlast  out  1  output end of packet.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  downstream ready.
- occupancy  out  clog2(FIFO_DEPTH)+1  number of stored words.
- packet_count  out  clog2(FIFO_DEPTH)+1  number of stored words with tlast=1.

Behaviour:
- Storage:
  - FIFO_DEPTH-entry register array holding {tdata, tkeep, tuser, tlast}.
  - wr_ptr and rd_ptr are clog2(FIFO_DEPTH)+1 bits wide; the MSB is the wrap bit.
  - empty = (wr_ptr == rd_ptr). full = (index bits equal, MSBs differ).
- Reset (arst high, asynchronous):
  - Pointers, counters, state and array clear to 0.
  - s_axis_tready = 0, m_axis_tvalid = 0, m_axis_tdata/tkeep/tuser/tlast = 0, occupancy = 0, packet_count = 0.
  - tready rises in the first cycle after arst deasserts.
  - Reset mid-packet discards all contents, including any partial packet.
- Write:
  - s_axis_tready = !full && !arst.
  - A transfer occurs when s_axis_tvalid && s_axis_tready; the word is stored at wr_ptr and wr_ptr increments.
- Read:
  - m_axis_* data fields are driven from array[rd_ptr] (first-word fall-through).
  - A transfer occurs when m_axis_tvalid && m_axis_tready; rd_ptr increments.
- Latency: a word written at edge N is presented with m_axis_tvalid high after edge N (1 cycle), subject to packet gating.
- No pass-through:
  - When full, no write is accepted, even if a read occurs in the same cycle.
  - When empty, m_axis_tvalid = 0.
- Counters: occupancy and packet_count are registered.
  - occupancy: +1 on write only, -1 on read only, unchanged on simultaneous write and read.
  - packet_count: same rules, applied to writes and reads of tlast=1 words.
- Wrap-around: pointers wrap modulo 2*FIFO_DEPTH with no bubble cycle.
- PACKET_MODE=0: m_axis_tvalid = !empty.
- PACKET_MODE=1, two-state FSM:
  - STORE: m_axis_tvalid = !empty && (packet_count != 0).
    - Go to CUT when full && packet_count == 0 (packet larger than the FIFO).
  - CUT: m_axis_tvalid = !empty.
    - Return to STORE on the read transfer of a tlast=1 word.
    - Latched so an oversize packet drains to completion even after the FIFO is no longer full.
  - In STORE with packet_count > 0: the gate stays open while the earliest buffered packet drains. packet_count decrements only when that tlast is read, so valid never drops mid-packet.
  - Valid, once asserted, holds until a handshake (AXIS rule).
- Data output registers hold their value while m_axis_tvalid && !m_axis_tready.

Test Plan:
- Reset/idle (DEPTH=4, BUS_WIDTH=2): hold arst 3 cycles, then release -> all outputs 0 during reset; s_axis_tready=1 on the next cycle; occupancy=0.
- PACKET_MODE=0 fill/drain: write 0x1111, 0x2222, 0x3333, 0x4444 with m_axis_tready=0 -> tready=0 after the 4th write and occupancy=4. Then m_axis_tready=1 -> the same order out, 1 word/cycle, tvalid falls after 0x4444.
- Simultaneous and wrap: stream 20 words with both sides continuously ready -> occupancy settles at 1, output order matches input, no gaps across pointer wrap.
- PACKET_MODE=1 gating: write 3-word packet (tlast on 3rd, tkeep=2'b01 on last, tuser=1), m_axis_tready=1 -> m_axis_tvalid stays 0 until the cycle after tlast is written. Then 3 words emerge with tkeep/tuser intact; packet_count goes 1 -> 0.
- PACKET_MODE=1 cut-through: write 6-word packet into DEPTH=4 -> FIFO fills, FSM enters CUT, tvalid=1. All 6 words drain in order; FSM returns to STORE after tlast, and a following single-word packet waits for its tlast.
- Backpressure hold and mid-operation reset: m_axis_tready toggles 1010 -> tdata stable while stalled. Assert arst with 2 words stored -> occupancy=0, tvalid=0 asynchronously.

Source files
------------

// File: rtl/axis_tiny_packet_fifo.sv
`default_nettype none
// ============================================================================
// Module   : axis_tiny_packet_fifo
// Purpose  : Register-based AXI-Stream FIFO that carries tkeep/tuser/tlast and
//            reports its occupancy and buffered packet count. With PACKET_MODE
//            set it forwards a packet only after its tlast is stored. If a
//            packet cannot fit in the FIFO, it latches into cut-through so the
//            packet can drain.
// Revision : 1.0 - initial release
// ============================================================================
module axis_tiny_packet_fifo #(
    parameter int FIFO_DEPTH  = 4,
    parameter int BUS_WIDTH   = 8,
    parameter int USER_WIDTH  = 1,
    parameter int PACKET_MODE = 0
) (
    input  logic                            aclk,
    input  logic                            arst,
    input  logic [BUS_WIDTH*8-1:0]          s_axis_tdata,
    input  logic [BUS_WIDTH-1:0]            s_axis_tkeep,
    input  logic [USER_WIDTH-1:0]           s_axis_tuser,
    input  logic                            s_axis_tlast,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    output logic [BUS_WIDTH*8-1:0]          m_axis_tdata,
    output logic [BUS_WIDTH-1:0]            m_axis_tkeep,
    output logic [USER_WIDTH-1:0]           m_axis_tuser,
    output logic                            m_axis_tlast,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic [$clog2(FIFO_DEPTH):0]     occupancy,
    output logic [$clog2(FIFO_DEPTH):0]     packet_count
);

    localparam int c_AW = $clog2(FIFO_DEPTH);
    localparam int c_PW = c_AW + 1;
    localparam int c_DW = BUS_WIDTH * 8;
    localparam int c_EW = c_DW + BUS_WIDTH + USER_WIDTH + 1;
    localparam logic [c_PW-1:0] c_ONE = c_PW'(1);

    // Entry layout: {tdata, tkeep, tuser, tlast}; tlast sits in bit 0
    logic [c_EW-1:0] r_mem [FIFO_DEPTH];
    logic [c_PW-1:0] r_wr_ptr;
    logic [c_PW-1:0] r_rd_ptr;
    logic [c_PW-1:0] r_occ;
    logic [c_PW-1:0] r_pkt_cnt;

    logic            w_empty;
    logic            w_full;
    logic            w_valid;
    logic            w_wr;
    logic            w_rd;
    logic            w_wr_last;
    logic            w_rd_last;
    logic [c_EW-1:0] w_rd_word;

    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]) &&
                       (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]);
    assign w_rd_word = r_mem[r_rd_ptr[c_AW-1:0]];

    // Fullness is judged only from stored state, so a read in the same cycle
    // never lets a write through when the FIFO is full.
    assign w_wr      = s_axis_tvalid && !w_full;
    assign w_rd      = w_valid && m_axis_tready;
    assign w_wr_last = w_wr && s_axis_tlast;
    assign w_rd_last = w_rd && w_rd_word[0];

    // Storage array and pointers. The array is cleared so outputs read 0 in reset.
    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr[c_AW-1:0]] <= {s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tlast};
                r_wr_ptr <= r_wr_ptr + c_ONE;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + c_ONE;
            end
        end
    end

    // Word and packet counters. They do not change when a write and a read of the same kind coincide.
    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            r_occ     <= '0;
            r_pkt_cnt <= '0;
        end else begin
            case ({w_wr, w_rd})
                2'b10:   r_occ <= r_occ + c_ONE;
                2'b01:   r_occ <= r_occ - c_ONE;
                default: r_occ <= r_occ;
            endcase
            case ({w_wr_last, w_rd_last})
                2'b10:   r_pkt_cnt <= r_pkt_cnt + c_ONE;
                2'b01:   r_pkt_cnt <= r_pkt_cnt - c_ONE;
                default: r_pkt_cnt <= r_pkt_cnt;
            endcase
        end
    end

    generate
        if (PACKET_MODE != 0) begin : g_packet
            typedef enum logic [0:0] {
                ST_STORE = 1'b0,
                ST_CUT   = 1'b1
            } state_t;

            state_t r_state;

            // STORE: wait for a full packet. CUT: a packet larger than the FIFO drains through to its tlast.
            always_ff @(posedge aclk or posedge arst) begin
                if (arst) begin
                    r_state <= ST_STORE;
                end else begin
                    case (r_state)
                        ST_STORE: if (w_full && (r_pkt_cnt == '0)) r_state <= ST_CUT;
                        ST_CUT:   if (w_rd_last)                   r_state <= ST_STORE;
                        default:  r_state <= ST_STORE;
                    endcase
                end
            end

            // packet_count falls only when a tlast is read, so the gate stays open for a whole packet.
            assign w_valid = (r_state == ST_CUT) ? !w_empty
                                                 : (!w_empty && (r_pkt_cnt != '0));
        end else begin : g_plain
            assign w_valid = !w_empty;
        end
    endgenerate

    assign s_axis_tready = !w_full && !arst;
    assign m_axis_tvalid = w_valid;
    assign m_axis_tdata  = w_rd_word[c_EW-1 -: c_DW];
    assign m_axis_tkeep  = w_rd_word[USER_WIDTH+1 +: BUS_WIDTH];
    assign m_axis_tuser  = w_rd_word[1 +: USER_WIDTH];
    assign m_axis_tlast  = w_rd_word[0];
    assign occupancy     = r_occ;
    assign packet_count  = r_pkt_cnt;

endmodule
`default_nettype wire

// File: tb/tb_axis_tiny_packet_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_tiny_packet_fifo
// Purpose  : Self-checking bench for axis_tiny_packet_fifo. Instance 0 runs in
//            plain FIFO mode and instance 1 runs in packet mode. Both use
//            DEPTH=4 and BUS_WIDTH=2. A scoreboard queue holds the expected
//            output words.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axis_tiny_packet_fifo;

    logic             aclk = 1'b0;
    logic             arst = 1'b1;
    logic [1:0][15:0] s_tdata  = '0;
    logic [1:0][1:0]  s_tkeep  = '0;
    logic [1:0]       s_tuser  = '0;
    logic [1:0]       s_tlast  = '0;
    logic [1:0]       s_tvalid = '0;
    logic [1:0]       s_tready;
    logic [1:0][15:0] m_tdata;
    logic [1:0][1:0]  m_tkeep;
    logic [1:0]       m_tuser;
    logic [1:0]       m_tlast;
    logic [1:0]       m_tvalid;
    logic [1:0]       m_tready = '0;
    logic [1:0][2:0]  occ;
    logic [1:0][2:0]  pcnt;

    int               n_checks = 0;
    int               n_fail   = 0;
    logic [19:0]      q0[$];
    logic [19:0]      q1[$];
    logic [1:0]       acc      = '0;
    logic [1:0]       held_v   = '0;
    logic [1:0][19:0] held_w   = '0;

    typedef struct {
        logic [15:0] data;
        logic [1:0]  keep;
        logic        user;
        logic        last;
        logic [2:0]  exp_occ;
        logic [2:0]  exp_pc;
        logic        exp_sready;
    } vec_t;
    vec_t fill_tab[4];

    always #5 aclk = ~aclk;

    axis_tiny_packet_fifo #(.FIFO_DEPTH(4), .BUS_WIDTH(2), .USER_WIDTH(1), .PACKET_MODE(0)) u_dut0 (
        .aclk(aclk), .arst(arst),
        .s_axis_tdata(s_tdata[0]), .s_axis_tkeep(s_tkeep[0]), .s_axis_tuser(s_tuser[0:0]),
        .s_axis_tlast(s_tlast[0]), .s_axis_tvalid(s_tvalid[0]), .s_axis_tready(s_tready[0]),
        .m_axis_tdata(m_tdata[0]), .m_axis_tkeep(m_tkeep[0]), .m_axis_tuser(m_tuser[0:0]),
        .m_axis_tlast(m_tlast[0]), .m_axis_tvalid(m_tvalid[0]), .m_axis_tready(m_tready[0]),
        .occupancy(occ[0]), .packet_count(pcnt[0])
    );

    axis_tiny_packet_fifo #(.FIFO_DEPTH(4), .BUS_WIDTH(2), .USER_WIDTH(1), .PACKET_MODE(1)) u_dut1 (
        .aclk(aclk), .arst(arst),
        .s_axis_tdata(s_tdata[1]), .s_axis_tkeep(s_tkeep[1]), .s_axis_tuser(s_tuser[1:1]),
        .s_axis_tlast(s_tlast[1]), .s_axis_tvalid(s_tvalid[1]), .s_axis_tready(s_tready[1]),
        .m_axis_tdata(m_tdata[1]), .m_axis_tkeep(m_tkeep[1]), .m_axis_tuser(m_tuser[1:1]),
        .m_axis_tlast(m_tlast[1]), .m_axis_tvalid(m_tvalid[1]), .m_axis_tready(m_tready[1]),
        .occupancy(occ[1]), .packet_count(pcnt[1])
    );

    task automatic fail(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        n_fail++;
        $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        if (act !== req) begin
            fail(name, act, req);
        end else begin
            n_checks++;
        end
    endtask

    function automatic int qsize(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    // One clock cycle. At the falling edge it scores the output handshake,
    // checks that stalled outputs hold, and records the input handshake. It
    // returns 1 ns after the next rising edge.
    task automatic tick();
        logic [19:0] w;
        logic [19:0] e;
        @(negedge aclk);
        for (int d = 0; d < 2; d++) begin
            w      = {m_tdata[d], m_tkeep[d], m_tuser[d], m_tlast[d]};
            acc[d] = 1'b0;
            if (arst) begin
                held_v[d] = 1'b0;
            end else begin
                if (held_v[d]) begin
                    chk("hold_valid", 32'(m_tvalid[d]), 32'd1);
                    chk("hold_word", 32'(w), 32'(held_w[d]));
                end
                if (m_tvalid[d] && m_tready[d]) begin
                    if (qsize(d) == 0) begin
                        fail("sb_unexpected_word", 32'(w), 32'd0);
                    end else begin
                        e = (d == 0) ? q0.pop_front() : q1.pop_front();
                        chk("sb_word", 32'(w), 32'(e));
                    end
                end
                held_v[d] = m_tvalid[d] && !m_tready[d];
                held_w[d] = w;
                if (s_tvalid[d] && s_tready[d]) begin
                    if (d == 0) q0.push_back({s_tdata[d], s_tkeep[d], s_tuser[d], s_tlast[d]});
                    else        q1.push_back({s_tdata[d], s_tkeep[d], s_tuser[d], s_tlast[d]});
                    acc[d] = 1'b1;
                end
            end
        end
        if (arst) begin
            q0.delete();
            q1.delete();
        end
        @(posedge aclk);
        #1;
    endtask

    task automatic send(input int d, input logic [15:0] data, input logic [1:0] keep,
                        input logic user, input logic last);
        logic done;
        done        = 1'b0;
        s_tdata[d]  = data;
        s_tkeep[d]  = keep;
        s_tuser[d]  = user;
        s_tlast[d]  = last;
        s_tvalid[d] = 1'b1;
        for (int i = 0; i < 16 && !done; i++) begin
            tick();
            done = acc[d];
        end
        if (!done) fail("send_timeout", 32'(data), 32'd1);
        s_tvalid[d] = 1'b0;
    endtask

    task automatic drain(input int d, input int max_cycles);
        for (int i = 0; i < max_cycles && qsize(d) != 0; i++) begin
            tick();
        end
        chk("drain_left", 32'(qsize(d)), 32'd0);
    endtask

    task automatic chk_reset_outputs(input int d);
        chk("rst_s_tready", 32'(s_tready[d]), 32'd0);
        chk("rst_m_tvalid", 32'(m_tvalid[d]), 32'd0);
        chk("rst_m_word",   32'({m_tdata[d], m_tkeep[d], m_tuser[d], m_tlast[d]}), 32'd0);
        chk("rst_occ",      32'(occ[d]), 32'd0);
        chk("rst_pcnt",     32'(pcnt[d]), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        fill_tab[0] = '{16'h1111, 2'b11, 1'b0, 1'b0, 3'd1, 3'd0, 1'b1};
        fill_tab[1] = '{16'h2222, 2'b01, 1'b1, 1'b1, 3'd2, 3'd1, 1'b1};
        fill_tab[2] = '{16'h3333, 2'b10, 1'b0, 1'b0, 3'd3, 3'd1, 1'b1};
        fill_tab[3] = '{16'h4444, 2'b11, 1'b1, 1'b1, 3'd4, 3'd2, 1'b0};

        // Reset held for three cycles, then released
        arst = 1'b1;
        repeat (3) begin
            tick();
            chk_reset_outputs(0);
            chk_reset_outputs(1);
        end
        arst = 1'b0;
        tick();
        chk("post_rst_tready0", 32'(s_tready[0]), 32'd1);
        chk("post_rst_tready1", 32'(s_tready[1]), 32'd1);
        chk("post_rst_occ0", 32'(occ[0]), 32'd0);

        // Plain mode: fill using the table, then drain at one word per cycle
        m_tready[0] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(0, fill_tab[i].data, fill_tab[i].keep, fill_tab[i].user, fill_tab[i].last);
            chk("fill_occ",    32'(occ[0]), 32'(fill_tab[i].exp_occ));
            chk("fill_pcnt",   32'(pcnt[0]), 32'(fill_tab[i].exp_pc));
            chk("fill_sready", 32'(s_tready[0]), 32'(fill_tab[i].exp_sready));
            chk("fill_mvalid", 32'(m_tvalid[0]), 32'd1);
        end
        m_tready[0] = 1'b1;
        repeat (4) tick();
        chk("drain4_left", 32'(q0.size()), 32'd0);
        chk("drain4_mvalid", 32'(m_tvalid[0]), 32'd0);
        chk("drain4_occ", 32'(occ[0]), 32'd0);
        chk("drain4_pcnt", 32'(pcnt[0]), 32'd0);

        // Plain mode: 20-word stream with both sides ready, across several pointer wraps
        s_tvalid[0] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            s_tdata[0] = 16'hA000 + 16'(i);
            s_tkeep[0] = 2'b11;
            s_tuser[0] = i[0];
            s_tlast[0] = (i % 5 == 4);
            tick();
            chk("stream_acc", 32'(acc[0]), 32'd1);
            chk("stream_occ", 32'(occ[0]), 32'd1);
        end
        s_tvalid[0] = 1'b0;
        tick();
        chk("stream_end_occ", 32'(occ[0]), 32'd0);
        chk("stream_end_left", 32'(q0.size()), 32'd0);

        // Packet mode: a 3-word packet stays gated until its tlast is stored
        m_tready[1] = 1'b1;
        send(1, 16'h0A01, 2'b11, 1'b1, 1'b0);
        chk("gate_w0_valid", 32'(m_tvalid[1]), 32'd0);
        send(1, 16'h0A02, 2'b11, 1'b1, 1'b0);
        chk("gate_w1_valid", 32'(m_tvalid[1]), 32'd0);
        send(1, 16'h0A03, 2'b01, 1'b1, 1'b1);
        chk("gate_last_valid", 32'(m_tvalid[1]), 32'd1);
        chk("gate_last_pcnt", 32'(pcnt[1]), 32'd1);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("gate_mid_valid", 32'(m_tvalid[1]), 32'd1);
            chk("gate_mid_pcnt", 32'(pcnt[1]), 32'd1);
        end
        tick();
        chk("gate_done_pcnt", 32'(pcnt[1]), 32'd0);
        chk("gate_done_valid", 32'(m_tvalid[1]), 32'd0);
        chk("gate_done_left", 32'(q1.size()), 32'd0);

        // Packet mode: a 6-word packet overfills the FIFO and forces cut-through
        for (int i = 0; i < 4; i++) begin
            send(1, 16'hC000 + 16'(i), 2'b11, 1'b0, 1'b0);
            chk("cut_fill_valid", 32'(m_tvalid[1]), 32'd0);
        end
        chk("cut_full_occ", 32'(occ[1]), 32'd4);
        chk("cut_full_sready", 32'(s_tready[1]), 32'd0);
        tick();
        chk("cut_enter_valid", 32'(m_tvalid[1]), 32'd1);
        chk("cut_enter_pcnt", 32'(pcnt[1]), 32'd0);
        send(1, 16'hC004, 2'b11, 1'b0, 1'b0);
        send(1, 16'hC005, 2'b10, 1'b1, 1'b1);
        drain(1, 20);
        chk("cut_done_occ", 32'(occ[1]), 32'd0);
        // The next packet is gated again until its tlast arrives
        send(1, 16'hD000, 2'b11, 1'b0, 1'b0);
        chk("store_again_valid", 32'(m_tvalid[1]), 32'd0);
        repeat (3) begin
            tick();
            chk("store_wait_valid", 32'(m_tvalid[1]), 32'd0);
        end
        send(1, 16'hD001, 2'b01, 1'b1, 1'b1);
        chk("store_release_valid", 32'(m_tvalid[1]), 32'd1);
        drain(1, 10);

        // Plain mode: downstream ready toggles 1010 while three words drain
        m_tready[0] = 1'b0;
        send(0, 16'hE000, 2'b11, 1'b0, 1'b0);
        send(0, 16'hE001, 2'b01, 1'b1, 1'b0);
        send(0, 16'hE002, 2'b10, 1'b0, 1'b1);
        for (int i = 0; i < 12 && q0.size() != 0; i++) begin
            m_tready[0] = (i % 2 == 0);
            tick();
        end
        chk("bp_left", 32'(q0.size()), 32'd0);
        m_tready[0] = 1'b0;

        // Asynchronous reset asserted while two words are stored
        send(0, 16'hF000, 2'b11, 1'b0, 1'b0);
        send(0, 16'hF001, 2'b11, 1'b0, 1'b1);
        chk("pre_rst_occ", 32'(occ[0]), 32'd2);
        arst = 1'b1;
        #1;
        chk("async_rst_occ", 32'(occ[0]), 32'd0);
        chk("async_rst_valid", 32'(m_tvalid[0]), 32'd0);
        chk("async_rst_sready", 32'(s_tready[0]), 32'd0);
        tick();
        arst = 1'b0;
        tick();
        chk("after_rst_occ", 32'(occ[0]), 32'd0);
        chk("after_rst_valid", 32'(m_tvalid[0]), 32'd0);
        chk("after_rst_sready", 32'(s_tready[0]), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
